batrider_pcm_arb: RTL and testbench

//  Serves both jt6295 PCM ROM ports of the sound block from one 16-bit SDRAM read slot.

---
 rtl/batrider_pcm_arb.sv | 136 +++++++++++++
 tb/tb_batrider_pcm_arb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/batrider_pcm_arb.sv
// Shares one 16-bit SDRAM read slot between the two jt6295 PCM ROM ports.
// Each client keeps a one-word cache. Misses are served round-robin.
module batrider_pcm_arb #(
  parameter int unsigned        SDR_AW = 22,
  parameter logic [SDR_AW-1:0]  BASE   = '0
) (
  input  logic              CLK96,
  input  logic              RESET96_N,
  input  logic              PCM_CS,
  input  logic [20:0]       PCM_ADDR,
  output logic [7:0]        PCM_DOUT,
  output logic              PCM_OK,
  input  logic              PCM1_CS,
  input  logic [20:0]       PCM1_ADDR,
  output logic [7:0]        PCM1_DOUT,
  output logic              PCM1_OK,
  output logic              SDR_CS,
  output logic [SDR_AW-1:0] SDR_ADDR,
  input  logic [15:0]       SDR_DATA,
  input  logic              SDR_OK
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t             state_q, state_d;
  logic               valid0_q, valid0_d, valid1_q, valid1_d;
  logic [19:0]        tag0_q, tag0_d, tag1_q, tag1_d, gtag_q, gtag_d;
  logic [15:0]        data0_q, data0_d, data1_q, data1_d;
  logic               sdr_cs_q, sdr_cs_d;
  logic [SDR_AW-1:0]  sdr_addr_q, sdr_addr_d;
  logic               rr_q, rr_d, gnt_q, gnt_d;

  logic               hit0, hit1, miss0, miss1, g;
  logic [19:0]        gaddr;

  assign hit0      = valid0_q && (tag0_q == PCM_ADDR[20:1]);
  assign hit1      = valid1_q && (tag1_q == PCM1_ADDR[20:1]);
  assign miss0     = PCM_CS && !hit0;
  assign miss1     = PCM1_CS && !hit1;

  assign PCM_OK    = hit0;
  assign PCM1_OK   = hit1;
  assign PCM_DOUT  = PCM_ADDR[0]  ? data0_q[15:8] : data0_q[7:0];
  assign PCM1_DOUT = PCM1_ADDR[0] ? data1_q[15:8] : data1_q[7:0];
  assign SDR_CS    = sdr_cs_q;
  assign SDR_ADDR  = sdr_addr_q;

  always_comb begin
    state_d    = state_q;
    valid0_d   = valid0_q;
    valid1_d   = valid1_q;
    tag0_d     = tag0_q;
    tag1_d     = tag1_q;
    gtag_d     = gtag_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    sdr_cs_d   = sdr_cs_q;
    sdr_addr_d = sdr_addr_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    g          = 1'b0;
    gaddr      = '0;
    case (state_q)
      ST_IDLE: begin
        if (miss0 || miss1) begin
          g          = (miss0 && miss1) ? rr_q : miss1;
          gaddr      = g ? PCM1_ADDR[20:1] : PCM_ADDR[20:1];
          sdr_addr_d = BASE + SDR_AW'(gaddr);
          sdr_cs_d   = 1'b1;
          gtag_d     = gaddr;
          gnt_d      = g;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (SDR_OK) begin
          sdr_cs_d = 1'b0;
          // The non-granted client shares the fill when it sits on the same word.
          if (gnt_q) begin
            data1_d  = SDR_DATA;
            tag1_d   = gtag_q;
            valid1_d = 1'b1;
            if (PCM_CS && (PCM_ADDR[20:1] == gtag_q)) begin
              data0_d  = SDR_DATA;
              tag0_d   = gtag_q;
              valid0_d = 1'b1;
            end
          end else begin
            data0_d  = SDR_DATA;
            tag0_d   = gtag_q;
            valid0_d = 1'b1;
            if (PCM1_CS && (PCM1_ADDR[20:1] == gtag_q)) begin
              data1_d  = SDR_DATA;
              tag1_d   = gtag_q;
              valid1_d = 1'b1;
            end
          end
          rr_d    = ~gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state_q    <= ST_IDLE;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      tag0_q     <= '0;
      tag1_q     <= '0;
      gtag_q     <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      sdr_cs_q   <= 1'b0;
      sdr_addr_q <= BASE;
      rr_q       <= 1'b0;
      gnt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      tag0_q     <= tag0_d;
      tag1_q     <= tag1_d;
      gtag_q     <= gtag_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      sdr_cs_q   <= sdr_cs_d;
      sdr_addr_q <= sdr_addr_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
    end
  end

endmodule

// File: tb/tb_batrider_pcm_arb.sv
// Directed bench for batrider_pcm_arb with a nonzero BASE so offset and wrap are visible.
module tb_batrider_pcm_arb;

  logic        CLK96 = 1'b0;
  logic        RESET96_N;
  logic        PCM_CS, PCM1_CS;
  logic [20:0] PCM_ADDR, PCM1_ADDR;
  logic [7:0]  PCM_DOUT, PCM1_DOUT;
  logic        PCM_OK, PCM1_OK;
  logic        SDR_CS;
  logic [21:0] SDR_ADDR;
  logic [15:0] SDR_DATA;
  logic        SDR_OK;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  batrider_pcm_arb #(.SDR_AW(22), .BASE(22'h3F0000)) dut (
    .CLK96(CLK96), .RESET96_N(RESET96_N),
    .PCM_CS(PCM_CS), .PCM_ADDR(PCM_ADDR), .PCM_DOUT(PCM_DOUT), .PCM_OK(PCM_OK),
    .PCM1_CS(PCM1_CS), .PCM1_ADDR(PCM1_ADDR), .PCM1_DOUT(PCM1_DOUT), .PCM1_OK(PCM1_OK),
    .SDR_CS(SDR_CS), .SDR_ADDR(SDR_ADDR), .SDR_DATA(SDR_DATA), .SDR_OK(SDR_OK)
  );

  always #5 CLK96 = ~CLK96;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK96);
    #1;
  endtask

  task automatic pulse_ok(input logic [15:0] d);
    SDR_DATA = d;
    SDR_OK   = 1'b1;
    tick();
    SDR_OK   = 1'b0;
    #1;
  endtask

  initial begin
    RESET96_N = 1'b0;
    PCM_CS = 1'b0; PCM1_CS = 1'b0;
    PCM_ADDR = '0; PCM1_ADDR = '0;
    SDR_DATA = '0; SDR_OK = 1'b0;
    tick(); tick();
    check("rst_ok0",   {31'd0, PCM_OK}, 32'd0);
    check("rst_ok1",   {31'd0, PCM1_OK}, 32'd0);
    check("rst_dout0", {24'd0, PCM_DOUT}, 32'h00);
    check("rst_dout1", {24'd0, PCM1_DOUT}, 32'h00);
    check("rst_cs",    {31'd0, SDR_CS}, 32'd0);
    check("rst_addr",  {10'd0, SDR_ADDR}, 32'h3F0000);
    RESET96_N = 1'b1;
    tick();

    // single fetch, byte select, no refetch on same-word move
    PCM_CS = 1'b1; PCM_ADDR = 21'h000000;
    tick();
    check("a_cs",   {31'd0, SDR_CS}, 32'd1);
    check("a_addr", {10'd0, SDR_ADDR}, 32'h3F0000);
    check("a_ok_miss", {31'd0, PCM_OK}, 32'd0);
    tick();
    check("a_cs_hold", {31'd0, SDR_CS}, 32'd1);
    pulse_ok(16'hBEEF);
    check("a_ok",   {31'd0, PCM_OK}, 32'd1);
    check("a_dout", {24'd0, PCM_DOUT}, 32'hEF);
    check("a_cs_drop", {31'd0, SDR_CS}, 32'd0);
    check("a_ok1_nocs", {31'd0, PCM1_OK}, 32'd0);
    PCM_ADDR = 21'h000001; #1;
    check("a_dout_hi", {24'd0, PCM_DOUT}, 32'hBE);
    check("a_ok_hi",   {31'd0, PCM_OK}, 32'd1);
    tick(); tick();
    check("a_no_refetch", {31'd0, SDR_CS}, 32'd0);

    // CS low: no fetch, cached word still readable
    PCM_CS = 1'b0; PCM_ADDR = 21'h000300;
    tick(); tick();
    check("b_no_cs", {31'd0, SDR_CS}, 32'd0);
    PCM_ADDR = 21'h000000; #1;
    check("b_ok",   {31'd0, PCM_OK}, 32'd1);
    check("b_dout", {24'd0, PCM_DOUT}, 32'hEF);

    // reset during WAIT, late SDR_OK ignored
    PCM_CS = 1'b1; PCM_ADDR = 21'h000300;
    tick();
    check("c_cs", {31'd0, SDR_CS}, 32'd1);
    RESET96_N = 1'b0; #1;
    check("c_cs_async", {31'd0, SDR_CS}, 32'd0);
    check("c_addr_async", {10'd0, SDR_ADDR}, 32'h3F0000);
    PCM_CS = 1'b0; PCM_ADDR = 21'h000000; #1;
    check("c_ok_async", {31'd0, PCM_OK}, 32'd0);
    SDR_DATA = 16'h1234; SDR_OK = 1'b1;
    tick();
    SDR_OK = 1'b0;
    RESET96_N = 1'b1;
    tick();
    pulse_ok(16'h1234);
    check("c_ok_late", {31'd0, PCM_OK}, 32'd0);
    check("c_dout_late", {24'd0, PCM_DOUT}, 32'h00);
    check("c_cs_late", {31'd0, SDR_CS}, 32'd0);

    // double miss with rr=0: client 0 then client 1
    PCM_CS = 1'b1; PCM1_CS = 1'b1;
    PCM_ADDR = 21'h000010; PCM1_ADDR = 21'h100020;
    tick();
    check("d_addr0", {10'd0, SDR_ADDR}, 32'h3F0008);
    tick();
    pulse_ok(16'h1357);
    check("d_ok0",   {31'd0, PCM_OK}, 32'd1);
    check("d_dout0", {24'd0, PCM_DOUT}, 32'h57);
    check("d_ok1_pending", {31'd0, PCM1_OK}, 32'd0);
    tick();
    check("d_cs1",   {31'd0, SDR_CS}, 32'd1);
    check("d_addr1", {10'd0, SDR_ADDR}, 32'h070010);
    pulse_ok(16'hA1B2);
    check("d_ok1",   {31'd0, PCM1_OK}, 32'd1);
    check("d_dout1", {24'd0, PCM1_DOUT}, 32'hB2);

    // single client-0 grant leaves rr=1; next double miss goes to client 1 first
    PCM_ADDR = 21'h000020;
    tick();
    check("d2_addr", {10'd0, SDR_ADDR}, 32'h3F0010);
    pulse_ok(16'h0F0E);
    check("d2_dout", {24'd0, PCM_DOUT}, 32'h0E);
    PCM_ADDR = 21'h000500; PCM1_ADDR = 21'h000601;
    tick();
    check("d3_addr_first", {10'd0, SDR_ADDR}, 32'h3F0300);
    pulse_ok(16'hC3D4);
    check("d3_dout1", {24'd0, PCM1_DOUT}, 32'hC3);
    check("d3_ok0_pending", {31'd0, PCM_OK}, 32'd0);
    tick();
    check("d3_addr_second", {10'd0, SDR_ADDR}, 32'h3F0280);
    pulse_ok(16'h5A6B);
    check("d3_ok0",   {31'd0, PCM_OK}, 32'd1);
    check("d3_dout0", {24'd0, PCM_DOUT}, 32'h6B);

    // shared word: one fetch fills both
    PCM_ADDR = 21'h000040; PCM1_ADDR = 21'h000041;
    tick();
    check("e_addr", {10'd0, SDR_ADDR}, 32'h3F0020);
    pulse_ok(16'h9A8B);
    check("e_ok0",   {31'd0, PCM_OK}, 32'd1);
    check("e_ok1",   {31'd0, PCM1_OK}, 32'd1);
    check("e_dout0", {24'd0, PCM_DOUT}, 32'h8B);
    check("e_dout1", {24'd0, PCM1_DOUT}, 32'h9A);
    tick(); tick();
    check("e_single_fetch", {31'd0, SDR_CS}, 32'd0);

    // address moves while in WAIT
    PCM1_CS = 1'b0;
    PCM_ADDR = 21'h000100;
    tick();
    check("f_addr_a", {10'd0, SDR_ADDR}, 32'h3F0080);
    PCM_ADDR = 21'h000200; #1;
    check("f_ok_drop", {31'd0, PCM_OK}, 32'd0);
    tick();
    check("f_addr_hold", {10'd0, SDR_ADDR}, 32'h3F0080);
    pulse_ok(16'h7788);
    check("f_cs_drop", {31'd0, SDR_CS}, 32'd0);
    check("f_ok_miss", {31'd0, PCM_OK}, 32'd0);
    tick();
    check("f_cs_again", {31'd0, SDR_CS}, 32'd1);
    check("f_addr_b", {10'd0, SDR_ADDR}, 32'h3F0100);
    PCM_ADDR = 21'h000101; #1;
    check("f_old_fill_ok",   {31'd0, PCM_OK}, 32'd1);
    check("f_old_fill_dout", {24'd0, PCM_DOUT}, 32'h77);
    pulse_ok(16'h4455);
    PCM_ADDR = 21'h000200; #1;
    check("f_new_ok",   {31'd0, PCM_OK}, 32'd1);
    check("f_new_dout", {24'd0, PCM_DOUT}, 32'h55);

    // silent wrap of BASE + word address
    PCM_ADDR = 21'h1FFFFE;
    tick();
    check("g_wrap_addr", {10'd0, SDR_ADDR}, 32'h0EFFFF);
    pulse_ok(16'h0102);
    check("g_wrap_dout", {24'd0, PCM_DOUT}, 32'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
